pipelined_rca: RTL



---
 rtl/pipelined_rca.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: each of WIDTH/CHUNK stages ripples one
// CHUNK-bit slice, passing the carry and partial result forward under a valid/ready chain.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // Stage k advances whenever rdy[k] is 1; otherwise it holds everything.
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES-1];
  logic [WIDTH-1:0]  a_d [STAGES-1];
  logic [WIDTH-1:0]  b_q [STAGES-1];
  logic [WIDTH-1:0]  b_d [STAGES-1];
  logic              m_q, m_d;

  // Returns {carry into slice MSB, carry out, slice sum}.
  function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic [CHUNK:0] t;
    t = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    return {x[CHUNK-1] ^ y[CHUNK-1] ^ t[CHUNK-1], t};
  endfunction

  always_comb begin
    logic [CHUNK+1:0] r;
    logic             nxt;
    nxt = out_ready;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || nxt;
      nxt    = rdy[k];
    end

    v_d[0] = in_valid;
    a_d[0] = a;
    b_d[0] = sub ? ~b : b;
    r      = slice_add(a[CHUNK-1:0], b_d[0][CHUNK-1:0], sub | cin);
    s_d[0] = '0;
    s_d[0][CHUNK-1:0] = r[CHUNK-1:0];
    c_d[0] = r[CHUNK];

    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      r      = slice_add(a_q[k-1][k*CHUNK +: CHUNK], b_q[k-1][k*CHUNK +: CHUNK], c_q[k-1]);
      s_d[k] = s_q[k-1];
      s_d[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
      c_d[k] = r[CHUNK];
    end
    // r now holds the top slice, whose MSB carry-in feeds the overflow rule.
    m_d = r[CHUNK+1];

    for (int k = 1; k < STAGES - 1; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
  end

  // Data registers load only with valid contents so results stay put across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      c_q <= '0;
      m_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) s_q[k] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) v_q[k] <= v_d[k];
        if (rdy[k] && v_d[k]) begin
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        if (rdy[k] && v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
        end
      end
      if (rdy[STAGES-1] && v_d[STAGES-1]) m_q <= m_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = m_q ^ c_q[STAGES-1];

endmodule
